// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and constants for the data memory controller
//
// Purpose: FSM state encoding, access status codes and the default base
// address shared by data_mem_ctrl and its testbench.
// Ports: none (package).
package data_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_CONFLICT = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - single-port DEPTH x 32 RAM, synchronous write
//
// Purpose: word storage behind data_mem_ctrl. Writes happen on the rising
// clock edge when i_we is high; read data is combinational from i_addr and
// is registered by the controller. Contents are never reset.
// Ports:
//   clk      in   clock, rising edge
//   i_we     in   write enable
//   i_addr   in   word index
//   i_wdata  in   write data
//   o_rdata  out  read data at i_addr
module data_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data memory slave for the multicycle core's MEM stage
//
// Purpose: detects rising edges of MemRead|MemWrite while idle, classifies
// the request, waits LATENCY cycles, then completes the access with a
// one-cycle ready pulse and a registered err status.
// Optional feature macro: DATA_MEM_CTRL_STATS_EN adds rd_count/wr_count,
// saturating counts of ok loads and stores.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   dAddress    in   byte address
//   dWriteData  in   store data
//   MemRead     in   load request level
//   MemWrite    in   store request level
//   dReadData   out  registered load data
//   ready       out  one-cycle completion pulse
//   busy        out  high while an access is in flight
//   err         out  status of the last completed access
//   rd_count    out  ok load count (DATA_MEM_CTRL_STATS_EN only)
//   wr_count    out  ok store count (DATA_MEM_CTRL_STATS_EN only)
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  output logic        ready,
  output logic        busy,
  output logic [1:0]  err
`ifdef DATA_MEM_CTRL_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic          r_req_d;
  logic          w_req;
  logic          w_req_edge;
  logic          w_start;
  logic          w_complete;
  logic [31:0]   w_off;
  logic [1:0]    w_err_class;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_is_write;
  logic [1:0]    r_err_lat;
  logic [3:0]    r_cnt;
  logic          r_ready;
  logic [1:0]    r_err;
  logic [31:0]   r_rdata;
  logic [31:0]   w_ram_rdata;
  logic          w_we;

  // The core holds request levels for several cycles; only a rising edge counts.
  assign w_req      = MemRead | MemWrite;
  assign w_req_edge = w_req & ~r_req_d;
  assign w_off      = dAddress - BASE_ADDR;

  always_comb begin
    w_err_class = ERR_OK;
    if (MemRead && MemWrite) begin
      w_err_class = ERR_CONFLICT;
    end else if (dAddress[1:0] != 2'b00) begin
      w_err_class = ERR_MISALIGN;
    end else if ((dAddress < BASE_ADDR) || (w_off >= SPAN)) begin
      w_err_class = ERR_RANGE;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_edge) begin
          w_start      = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_complete   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_d    <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_err_lat  <= ERR_OK;
      r_cnt      <= 4'd0;
      r_ready    <= 1'b0;
      r_err      <= ERR_OK;
      r_rdata    <= '0;
    end else begin
      r_req_d <= w_req;
      r_ready <= w_complete;
      if (w_start) begin
        r_cnt      <= CNT_INIT;
        r_idx      <= w_off[AW+1:2];
        r_wdata    <= dWriteData;
        // A conflicting request completes as a failed load, so it zeroes dReadData.
        r_is_write <= MemWrite & ~MemRead;
        r_err_lat  <= w_err_class;
      end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_complete) begin
        r_err <= r_err_lat;
        if (!r_is_write) begin
          r_rdata <= (r_err_lat == ERR_OK) ? w_ram_rdata : 32'h0;
        end
      end
    end
  end

  // Stores commit only on the completing edge, so a reset mid-access drops them.
  assign w_we = w_complete & r_is_write & (r_err_lat == ERR_OK);

  data_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign dReadData = r_rdata;
  assign ready     = r_ready;
  assign busy      = (r_state == BUSY);
  assign err       = r_err;

`ifdef DATA_MEM_CTRL_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_count <= 16'h0;
      r_wr_count <= 16'h0;
    end else if (w_complete && (r_err_lat == ERR_OK)) begin
      if (r_is_write) begin
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'h1;
      end else begin
        if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'h1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule
